// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit block and the receive block.
// Both sides take their baud timing and status-word layout from here.
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT  = 217;
  localparam int STOP_BITS_DEFAULT = 1;
  localparam int UART_FLAG_BIT     = 15;
  localparam int DATA_BITS         = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Line level for the given transmitter state; data bits come from the shift LSB.
  function automatic logic tx_level(input tx_state_e st, input logic data_bit);
    logic level;
    case (st)
      TX_IDLE:  level = 1'b1;
      TX_START: level = 1'b0;
      TX_DATA:  level = data_bit;
      TX_STOP:  level = 1'b1;
      default:  level = 1'b1;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Modulo-DIV bit-period counter with synchronous clear and restart.
// tick marks the terminal count (DIV-1) while the counter is enabled.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        restart,
  input  logic        enable,
  output logic        tick,
  output logic [15:0] count
);

  localparam logic [15:0] TERMINAL = 16'(DIV - 1);

  logic [15:0] count_r;

  assign tick  = enable && (count_r == TERMINAL);
  assign count = count_r;

  // Count 0..DIV-1 while enabled; restart realigns the period to a new frame.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= 16'd0;
    end else if (restart) begin
      count_r <= 16'd0;
    end else if (enable) begin
      if (count_r == TERMINAL) begin
        count_r <= 16'd0;
      end else begin
        count_r <= count_r + 16'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises a CPU-written byte as an 8N1 (or 8N2) frame.
// TX and the busy flag are both registered so they change in the same cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_DEFAULT,
  parameter int STOP_BITS = STOP_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] in,
  output logic        TX,
  output logic [15:0] out
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic [1:0]  STOP_INIT = 2'(STOP_BITS);

  tx_state_e   state_r, state_n;
  logic [7:0]  shift_r, shift_n;
  logic [2:0]  bit_idx_r, bit_idx_n;
  logic [1:0]  stop_cnt_r, stop_cnt_n;
  logic        tx_r, tx_n;
  logic        busy_r;

  logic        restart_s;
  logic        baud_tick_s;
  logic [15:0] baud_count_s;
  logic        baud_fault_s;
  logic [7:0]  unused_in_hi_s;

  assign unused_in_hi_s = in[15:8];

  uart_baud_counter #(.DIV(BAUD_DIV)) u_baud (
    .clk     (clk),
    .clear   (clear),
    .restart (restart_s),
    .enable  (state_r != TX_IDLE),
    .tick    (baud_tick_s),
    .count   (baud_count_s)
  );

  // An out-of-range count can only come from a corrupted flop; abandon the frame.
  assign baud_fault_s = (state_r != TX_IDLE) && (baud_count_s > BAUD_LAST);

  // Next-state, shift and counter logic; TX is precomputed from the next state.
  always_comb begin
    state_n    = state_r;
    shift_n    = shift_r;
    bit_idx_n  = bit_idx_r;
    stop_cnt_n = stop_cnt_r;
    restart_s  = 1'b0;
    tx_n       = 1'b1;
    if (baud_fault_s) begin
      state_n    = TX_IDLE;
      shift_n    = 8'h00;
      bit_idx_n  = 3'd0;
      stop_cnt_n = 2'd0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          if (load) begin
            state_n    = TX_START;
            shift_n    = in[7:0];
            bit_idx_n  = 3'd0;
            stop_cnt_n = 2'd0;
            restart_s  = 1'b1;
          end else begin
            state_n = TX_IDLE;
          end
        end
        TX_START: begin
          if (baud_tick_s) begin
            state_n   = TX_DATA;
            bit_idx_n = 3'd0;
          end else begin
            state_n = TX_START;
          end
        end
        TX_DATA: begin
          if (baud_tick_s) begin
            shift_n   = {1'b0, shift_r[7:1]};
            bit_idx_n = bit_idx_r + 3'd1;
            if (bit_idx_r == LAST_IDX) begin
              state_n    = TX_STOP;
              stop_cnt_n = STOP_INIT;
            end else begin
              state_n = TX_DATA;
            end
          end else begin
            state_n = TX_DATA;
          end
        end
        TX_STOP: begin
          if (baud_tick_s) begin
            stop_cnt_n = stop_cnt_r - 2'd1;
            if (stop_cnt_r == 2'd1) begin
              state_n = TX_IDLE;
            end else begin
              state_n = TX_STOP;
            end
          end else begin
            state_n = TX_STOP;
          end
        end
        default: begin
          state_n = TX_IDLE;
        end
      endcase
    end
    tx_n = tx_level(state_n, shift_n[0]);
  end

  // State and output registers; clear wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r    <= TX_IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      stop_cnt_r <= 2'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      shift_r    <= shift_n;
      bit_idx_r  <= bit_idx_n;
      stop_cnt_r <= stop_cnt_n;
      tx_r       <= tx_n;
      busy_r     <= (state_n != TX_IDLE);
    end
  end

  // Status word: only the flag bit is ever set.
  always_comb begin
    out                = 16'h0000;
    out[UART_FLAG_BIT] = busy_r;
  end

  assign TX = tx_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames checked bit by bit, corner-case
// sequences, and a loopback receiver on 1- and 2-stop-bit instances.
module tb_uart_tx;

  localparam int B = 217;

  logic        clk = 1'b0;
  logic        clear;
  logic        load_a, load_b;
  logic [15:0] in_a, in_b;
  logic        tx_a, tx_b;
  logic [15:0] out_a, out_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] din;
    logic [9:0]  frame;   // {stop, d7..d0, start}
    logic [15:0] rx_exp;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_tx #(.BAUD_DIV(B), .STOP_BITS(1)) dut_a (
    .clk(clk), .clear(clear), .load(load_a), .in(in_a), .TX(tx_a), .out(out_a)
  );

  uart_tx #(.BAUD_DIV(B), .STOP_BITS(2)) dut_b (
    .clk(clk), .clear(clear), .load(load_b), .in(in_b), .TX(tx_b), .out(out_b)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic [15:0] get_out(input int w);
    return (w == 0) ? out_a : out_b;
  endfunction

  // Advance to the falling edge of cycle c (frame-relative).
  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drive_load(input int w, input logic [15:0] v);
    if (w == 0) begin
      load_a = 1'b1; in_a = v;
    end else begin
      load_b = 1'b1; in_b = v;
    end
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0;
    in_a = ~v; in_b = ~v;
  endtask

  task automatic start_load(input int w, input logic [15:0] v);
    drive_load(w, v);
    cyc = 1;
  endtask

  task automatic check_frame(input int w, input logic [9:0] frame, input int stops,
                             input int poke_at, input logic [15:0] poke_v);
    int nbits;
    int pt;
    logic exp_b;
    nbits = 9 + stops;
    for (int k = 0; k < nbits; k++) begin
      exp_b = (k < 10) ? frame[k] : 1'b1;
      for (int e = 0; e < 2; e++) begin
        pt = (e == 0) ? k * B + 1 : (k + 1) * B;
        if (poke_at > cyc && poke_at < pt) begin
          goto(poke_at);
          drive_load(w, poke_v);
          cyc++;
        end
        goto(pt);
        chk($sformatf("tx_bit%0d_e%0d", k, e), {15'd0, get_tx(w)}, {15'd0, exp_b});
        chk("busy", get_out(w), 16'h8000);
      end
    end
    goto(nbits * B + 1);
    chk("busy_end", get_out(w), 16'h0000);
    chk("tx_idle", {15'd0, get_tx(w)}, 16'h0001);
  endtask

  task automatic rx_loop(input int w, input logic [15:0] din, input logic [15:0] exp);
    logic [7:0]  r;
    logic [15:0] st;
    int t;
    start_load(w, din);
    while (get_tx(w) !== 1'b0 && cyc < 4) goto(cyc + 1);
    chk("rx_start_seen", {15'd0, get_tx(w)}, 16'h0000);
    t = cyc;
    for (int k = 0; k < 8; k++) begin
      goto(t + B / 2 + (k + 1) * B);
      r[k] = get_tx(w);
    end
    goto(t + B / 2 + 9 * B);
    chk("rx_stop", {15'd0, get_tx(w)}, 16'h0001);
    chk($sformatf("rx_data_%0d", w), {8'h00, r}, exp);
    st = get_out(w);
    while (st[15] && cyc < 12 * B) begin
      goto(cyc + 1);
      st = get_out(w);
    end
    chk("rx_busy_fall_cycle", 16'(cyc), 16'((w == 0) ? 10 * B + 1 : 11 * B + 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{din: 16'h0055, frame: 10'b1010101010, rx_exp: 16'h0055};
    vecs[1] = '{din: 16'hFFA3, frame: 10'b1101000110, rx_exp: 16'h00A3};
    vecs[2] = '{din: 16'h0000, frame: 10'b1000000000, rx_exp: 16'h0000};
    vecs[3] = '{din: 16'h00FF, frame: 10'b1111111110, rx_exp: 16'h00FF};
    vecs[4] = '{din: 16'h005A, frame: 10'b1010110100, rx_exp: 16'h005A};

    clear = 1'b1; load_a = 1'b0; load_b = 1'b0; in_a = 16'h0000; in_b = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", {15'd0, tx_a}, 16'h0001);
    chk("rst_out_a", out_a, 16'h0000);
    chk("rst_tx_b", {15'd0, tx_b}, 16'h0001);
    chk("rst_out_b", out_b, 16'h0000);
    clear = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      start_load(0, vecs[i].din);
      check_frame(0, vecs[i].frame, 1, 0, 16'h0000);
    end

    // Load while busy: the 0x42 write at cycle 500 must be ignored.
    start_load(0, 16'h0041);
    check_frame(0, 10'b1010000010, 1, 500, 16'h0042);

    // Back-to-back: second load in the first idle cycle (2171).
    start_load(0, 16'h000F);
    check_frame(0, 10'b1000011110, 1, 0, 16'h0000);
    start_load(0, 16'h00F0);
    check_frame(0, 10'b1111100000, 1, 0, 16'h0000);

    // Clear during data bit 3, then a clean frame.
    start_load(0, 16'h0033);
    goto(1000);
    chk("pre_clear_tx", {15'd0, tx_a}, 16'h0000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cyc++;
    chk("clear_tx", {15'd0, tx_a}, 16'h0001);
    chk("clear_out", out_a, 16'h0000);
    goto(cyc + 5);
    chk("clear_stays_idle", out_a, 16'h0000);
    start_load(0, 16'h007E);
    check_frame(0, 10'b1011111100, 1, 0, 16'h0000);

    // Clear and load together: byte dropped.
    clear = 1'b1; load_a = 1'b1; in_a = 16'h0012;
    @(negedge clk);
    clear = 1'b0; load_a = 1'b0;
    cyc = 0;
    goto(3);
    chk("clr_load_out", out_a, 16'h0000);
    chk("clr_load_tx", {15'd0, tx_a}, 16'h0001);

    for (int w = 0; w < 2; w++) begin
      for (int i = 2; i < 5; i++) begin
        rx_loop(w, vecs[i].din, vecs[i].rx_exp);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
